change_dispenser: RTL and testbench

- Coin-return block that sits downstream of the vending machine credit logic and drives the coin hopper.
- Reverse direction of the machine's coin interface: it takes an overpayment amount in cents and emits one-cycle quarter/dime/nickel pulses until that amount is paid back.
- Uses greedy coin selection and honours a hopper-ready stall.

---
 rtl/change_dispenser.sv | 139 +++++++++++++
 tb/tb_change_dispenser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin-return sequencer: pays back an overpayment as greedy quarter/dime/nickel
// pulses. It waits on the hopper and keeps a fixed gap between coin pulses.
module change_dispenser #(
  parameter int CW         = 8,
  parameter int MAX_CHANGE = 195,
  parameter int PULSE_GAP  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] amount,
  input  logic          hopper_ready,
  output logic          quarter,
  output logic          dime,
  output logic          nickel,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] remaining,
  output logic [1:0]    dbg_state
);

  // Handshake: start is a single-cycle request that is only sampled in IDLE.
  // hopper_ready qualifies a coin command in a DISPENSE cycle. No other
  // backpressure exists.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_GAP      = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(PULSE_GAP - 1);

  state_t        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic          quarter_q, quarter_d;
  logic          dime_q, dime_d;
  logic          nickel_q, nickel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          legal;

  assign legal = ((amount % CW'(5)) == '0) && (amount <= CW'(MAX_CHANGE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      quarter_q   <= 1'b0;
      dime_q      <= 1'b0;
      nickel_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      quarter_q   <= quarter_d;
      dime_q      <= dime_d;
      nickel_q    <= nickel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      remaining_q <= remaining_d;
    end
  end

  // GAP spans PULSE_GAP cycles, starting with the coin cycle itself.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start && legal) state_d = S_DISPENSE;
      end
      S_DISPENSE: begin
        if (remaining_q == '0) begin
          state_d = S_IDLE;
        end else if (hopper_ready && (PULSE_GAP > 0)) begin
          state_d = S_GAP;
          gap_d   = GAP_LAST;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_DISPENSE;
        else gap_d = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    quarter_d   = 1'b0;
    dime_d      = 1'b0;
    nickel_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    remaining_d = remaining_q;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) remaining_d = amount;
          else err_d = 1'b1;
        end
      end
      S_DISPENSE: begin
        if (remaining_q == '0) begin
          done_d = 1'b1;
        end else if (hopper_ready) begin
          if (remaining_q >= CW'(25)) begin
            quarter_d   = 1'b1;
            remaining_d = remaining_q - CW'(25);
          end else if (remaining_q >= CW'(10)) begin
            dime_d      = 1'b1;
            remaining_d = remaining_q - CW'(10);
          end else begin
            nickel_d    = 1'b1;
            remaining_d = remaining_q - CW'(5);
          end
        end
      end
      default: ;
    endcase
  end

  assign quarter   = quarter_q;
  assign dime      = dime_q;
  assign nickel    = nickel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remaining = remaining_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (PULSE_GAP 0 and 1) share the
// stimulus. Expected coin/done/err events come from a cycle-level model.
module tb_change_dispenser;
  localparam int W   = 30;
  localparam int BIG = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       reset, start, hopper_ready;
  logic [7:0] amount;

  logic       q0, d0, n0, busy0, done0, err0;
  logic [7:0] rem0;
  logic [1:0] st0;
  logic       q1, d1, n1, busy1, done1, err1;
  logic [7:0] rem1;
  logic [1:0] st1;

  change_dispenser #(.CW(8), .MAX_CHANGE(195), .PULSE_GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .hopper_ready(hopper_ready), .quarter(q0), .dime(d0), .nickel(n0),
    .busy(busy0), .done(done0), .err(err0), .remaining(rem0), .dbg_state(st0));

  change_dispenser #(.CW(8), .MAX_CHANGE(195), .PULSE_GAP(1)) u_g1 (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .hopper_ready(hopper_ready), .quarter(q1), .dime(d1), .nickel(n1),
    .busy(busy1), .done(done1), .err(err1), .remaining(rem1), .dbg_state(st1));

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rdy [0:8191];
  always @(posedge clk) begin
    #1;
    hopper_ready = rdy[cyc];
  end

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // Event word: {cycle, {err,done,quarter,dime,nickel}, busy, remaining}
  task automatic push(input int g, input int c, input logic [4:0] k,
                      input logic b, input int r);
    logic [W-1:0] e;
    e = {16'(c), k, b, 8'(r)};
    if (g == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // Reference model: greedy change, stalls on hopper schedule, G idle cycles
  // between coins. Events after cycle lim are dropped (reset abort).
  task automatic model(input int g, input int n, input int a, input int lim,
                       output int fin);
    int rem, t, c, coin;
    logic [4:0] k;
    if ((a % 5) != 0 || a > 195) begin
      if (n + 1 <= lim) push(g, n + 1, 5'b10000, 1'b0, 0);
      fin = n + 1;
      return;
    end
    rem = a;
    t = n + 1;
    while (rem > 0) begin
      while (!rdy[t] && t < 8191) t++;
      if (rem >= 25) begin coin = 25; k = 5'b00100; end
      else if (rem >= 10) begin coin = 10; k = 5'b00010; end
      else begin coin = 5; k = 5'b00001; end
      rem = rem - coin;
      c = t + 1;
      if (c <= lim) push(g, c, k, 1'b1, rem);
      t = c + g;
    end
    if (t + 1 <= lim) push(g, t + 1, 5'b01000, 1'b0, 0);
    fin = t + 1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_evt(input int g, input logic [4:0] k, input logic b,
                           input logic [7:0] r);
    logic [W-1:0] got, e;
    got = {16'(cyc), k, b, r};
    checks++;
    if ($countones(k) != 1) begin
      errors++;
      $display("FAIL onehot g=%0d cyc=%0d got kind=%b required one-hot", g, cyc, k);
    end
    checks++;
    if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_event g=%0d cyc=%0d got kind=%b busy=%b rem=%0d required none",
               g, cyc, k, b, r);
    end else begin
      e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL event g=%0d got cyc=%0d kind=%b busy=%b rem=%0d required cyc=%0d kind=%b busy=%b rem=%0d",
                 g, got[29:14], got[13:9], got[8], got[7:0], e[29:14], e[13:9], e[8], e[7:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if ((|{err0, done0, q0, d0, n0}) === 1'b1) check_evt(0, {err0, done0, q0, d0, n0}, busy0, rem0);
    if ((|{err1, done1, q1, d1, n1}) === 1'b1) check_evt(1, {err1, done1, q1, d1, n1}, busy1, rem1);
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string nm, input logic [13:0] got);
    checks++;
    if (got !== 14'd0) begin
      errors++;
      $display("FAIL %s got outputs=%h required 0", nm, got);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int a, input int lim, output int fin);
    int f0, f1, n;
    n = cyc;
    start = 1'b1;
    amount = 8'(a);
    model(0, n, a, lim, f0);
    model(1, n, a, lim, f1);
    fin = (f0 > f1) ? f0 : f1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL timeout cyc=%0d required completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int fin, n, a;
    reset = 1'b1;
    start = 1'b0;
    amount = '0;
    hopper_ready = 1'b1;
    for (int i = 0; i < 8192; i++) rdy[i] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_g0", {q0, d0, n0, busy0, done0, err0, rem0});
    check_zero("reset_g1", {q1, d1, n1, busy1, done1, err1, rem1});
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_start(40, BIG, fin);
    wait_until(fin + 1);
    do_start(95, BIG, fin);
    wait_until(fin + 1);

    n = cyc;
    for (int i = 1; i <= 4; i++) rdy[n + i] = 1'b0;
    do_start(30, BIG, fin);
    wait_until(n + 3);
    @(negedge clk);
    checks++;
    if (!(busy0 === 1'b1 && rem0 === 8'd30 && busy1 === 1'b1 && rem1 === 8'd30)) begin
      errors++;
      $display("FAIL stall_hold got busy=%b/%b rem=%0d/%0d required busy=1 rem=30",
               busy0, busy1, rem0, rem1);
    end
    wait_until(fin + 1);

    do_start(33, BIG, fin);
    wait_until(fin + 1);
    do_start(200, BIG, fin);
    wait_until(fin + 1);

    do_start(0, BIG, fin);
    wait_until(fin);
    do_start(10, BIG, fin);
    wait_until(fin + 1);

    n = cyc;
    do_start(195, n + 5, fin);
    wait_until(n + 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero("abort_g0", {q0, d0, n0, busy0, done0, err0, rem0});
    check_zero("abort_g1", {q1, d1, n1, busy1, done1, err1, rem1});
    @(posedge clk);
    #1;
    do_start(25, BIG, fin);
    wait_until(fin + 1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) a = int'($urandom_range(0, 255));
      else a = 5 * int'($urandom_range(0, 39));
      n = cyc;
      for (int i = 1; i <= 250; i++) rdy[n + i] = ($urandom_range(0, 3) != 0);
      do_start(a, BIG, fin);
      if ((a % 5) == 0 && a <= 195 && $urandom_range(0, 1) == 1) begin
        start = 1'b1;
        amount = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_until(fin + int'($urandom_range(0, 2)));
    end

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q0.size() != 0) begin
      errors++;
      $display("FAIL missing_g0 got pending=%0d required 0", exp_q0.size());
    end
    checks++;
    if (exp_q1.size() != 0) begin
      errors++;
      $display("FAIL missing_g1 got pending=%0d required 0", exp_q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
